// File: rtl/ahb_master_arbiter.sv
// Two-master AHB arbiter: M0 = CPU, M1 = DMA.
// Registered one-hot grants, address/data-phase owner tracking, ownership
// changes only at transfer boundaries (arbitration points). Policy layers:
// HLOCK, DMA starvation guard, per-tenure beat limit, reflex boost for M1,
// and fixed CPU priority as the fallback.
module ahb_master_arbiter #(
  parameter int unsigned MAX_HOLD     = 16,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] hbusreq,
  input  logic [1:0] hlock,
  input  logic [3:0] htrans_m,
  input  logic       hready,
  input  logic       reflex_boost,
  output logic [1:0] hgrant,
  output logic       hmaster,
  output logic       hmaster_data,
  output logic       hmastlock,
  output logic       handover,
  output logic       starve_evt
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [7:0] LP_MAX_HOLD   = 8'(MAX_HOLD);
  localparam logic [7:0] LP_STARVE     = 8'(STARVE_LIMIT);
  localparam logic [7:0] LP_CNT_MAX    = '1;

  typedef enum logic [1:0] {
    OWN0   = 2'd0,
    OWN1   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_hgrant;
  logic       r_hmaster;
  logic       r_hmaster_data;
  logic       r_handover;
  logic [7:0] r_beat_cnt;
  logic [7:0] r_starve_cnt;

  logic [1:0] w_own_trans;
  logic       w_own_req;
  logic       w_oth_req;
  logic       w_own_lock;
  logic       w_ap;
  logic       w_lock_ap;
  logic       w_winner;
  logic       w_starve_force;
  logic       w_hmaster_nxt;
  logic       w_handover;
  logic       w_starve_evt;
  logic [7:0] w_beat_nxt;
  logic [7:0] w_starve_nxt;

  // Current owner's view of the bus.
  assign w_own_trans = r_hmaster ? htrans_m[3:2] : htrans_m[1:0];
  assign w_own_req   = r_hmaster ? hbusreq[1]    : hbusreq[0];
  assign w_oth_req   = r_hmaster ? hbusreq[0]    : hbusreq[1];
  assign w_own_lock  = r_hmaster ? hlock[1]      : hlock[0];

  // Boundary: accepted cycle where the owner is idle or starting a new transfer.
  assign w_ap      = hready && ((w_own_trans == HTRANS_IDLE) ||
                                (w_own_trans == HTRANS_NONSEQ));
  assign w_lock_ap = w_ap && w_own_lock && w_own_req;

  // Winner selection for a non-locked arbitration point, first match wins.
  always_comb begin
    w_winner       = r_hmaster;
    w_starve_force = 1'b0;
    if (hbusreq[0] ^ hbusreq[1]) begin
      w_winner = hbusreq[1];
    end else if (!hbusreq[0]) begin
      w_winner = r_hmaster;
    end else if (r_starve_cnt >= LP_STARVE) begin
      w_winner       = 1'b1;
      w_starve_force = 1'b1;
    end else if (r_beat_cnt >= LP_MAX_HOLD) begin
      w_winner = ~r_hmaster;
    end else if (reflex_boost) begin
      w_winner = 1'b1;
    end else begin
      w_winner = 1'b0;
    end
  end

  // Next-state and next-owner decision; lock overrides all other rules.
  always_comb begin
    w_state_nxt   = r_state;
    w_hmaster_nxt = r_hmaster;
    w_starve_evt  = 1'b0;
    if (w_lock_ap) begin
      w_state_nxt = LOCKED;
    end else if (w_ap) begin
      w_hmaster_nxt = w_winner;
      w_state_nxt   = w_winner ? OWN1 : OWN0;
      w_starve_evt  = w_starve_force;
    end
  end

  assign w_handover = (w_hmaster_nxt != r_hmaster);

  // Counter next values; beats are not accumulated during a locked tenure.
  always_comb begin
    w_beat_nxt = r_beat_cnt;
    if (w_handover || !w_oth_req) begin
      w_beat_nxt = '0;
    end else if ((r_state != LOCKED) && !w_lock_ap && hready &&
                 w_own_trans[1] && (r_beat_cnt != LP_CNT_MAX)) begin
      w_beat_nxt = r_beat_cnt + 8'd1;
    end

    w_starve_nxt = r_starve_cnt;
    if (!hbusreq[1] || (w_handover && w_hmaster_nxt)) begin
      w_starve_nxt = '0;
    end else if (w_ap && !r_hmaster && !w_hmaster_nxt &&
                 (r_starve_cnt != LP_CNT_MAX)) begin
      w_starve_nxt = r_starve_cnt + 8'd1;
    end
  end

  // State register with registered grant, owner and handover pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= OWN0;
      r_hmaster  <= 1'b0;
      r_hgrant   <= 2'b01;
      r_handover <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hmaster  <= w_hmaster_nxt;
      r_hgrant   <= w_hmaster_nxt ? 2'b10 : 2'b01;
      r_handover <= w_handover;
    end
  end

  // Tenure beat counter and M1 starvation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt   <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_beat_cnt   <= w_beat_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Data-phase owner follows the address-phase owner on each accepted cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hmaster_data <= 1'b0;
    end else if (hready) begin
      r_hmaster_data <= r_hmaster;
    end
  end

  assign hgrant       = r_hgrant;
  assign hmaster      = r_hmaster;
  assign hmaster_data = r_hmaster_data;
  assign handover     = r_handover;
  assign starve_evt   = w_starve_evt;
  assign hmastlock    = (r_state == LOCKED) && (w_own_trans != HTRANS_IDLE);

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter with a rule-level reference model.
module tb_ahb_master_arbiter;

  localparam int HOLD   = 4;
  localparam int STARVE = 3;
  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] hbusreq = '0;
  logic [1:0] hlock = '0;
  logic [3:0] htrans_m = '0;
  logic       hready = 1'b1;
  logic       reflex_boost = 1'b0;
  logic [1:0] hgrant;
  logic       hmaster;
  logic       hmaster_data;
  logic       hmastlock;
  logic       handover;
  logic       starve_evt;

  int n_pass = 0;
  int n_total = 0;

  ahb_master_arbiter #(
    .MAX_HOLD    (HOLD),
    .STARVE_LIMIT(STARVE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hbusreq     (hbusreq),
    .hlock       (hlock),
    .htrans_m    (htrans_m),
    .hready      (hready),
    .reflex_boost(reflex_boost),
    .hgrant      (hgrant),
    .hmaster     (hmaster),
    .hmaster_data(hmaster_data),
    .hmastlock   (hmastlock),
    .handover    (handover),
    .starve_evt  (starve_evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int m_own, m_locked, m_beat, m_starve, m_data, m_hand;
  int t_own, t_tr, t_ap, t_lk, t_win, t_f, t_was_locked;

  function automatic int trans_of(input int who);
    return (who == 1) ? int'(htrans_m[3:2]) : int'(htrans_m[1:0]);
  endfunction

  function automatic int pick(input int own, output int forced);
    forced = 0;
    if (hbusreq == 2'b01) return 0;
    if (hbusreq == 2'b10) return 1;
    if (hbusreq == 2'b00) return own;
    if (m_starve >= STARVE) begin forced = 1; return 1; end
    if (m_beat >= HOLD) return 1 - own;
    if (reflex_boost) return 1;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own = 0; m_locked = 0; m_beat = 0; m_starve = 0; m_data = 0; m_hand = 0;
    end else begin
      t_own = m_own;
      t_tr = trans_of(t_own);
      t_ap = (hready && (t_tr == 0 || t_tr == 2)) ? 1 : 0;
      t_lk = (t_ap == 1 && hlock[t_own] && hbusreq[t_own]) ? 1 : 0;
      t_was_locked = m_locked;
      t_win = t_own;
      if (t_lk == 1) m_locked = 1;
      else if (t_ap == 1) begin
        m_locked = 0;
        t_win = pick(t_own, t_f);
      end
      if (t_win != t_own || !hbusreq[1 - t_own]) m_beat = 0;
      else if (t_was_locked == 0 && t_lk == 0 && hready && t_tr >= 2 && m_beat < 255)
        m_beat = m_beat + 1;
      if (!hbusreq[1] || (t_win == 1 && t_own == 0)) m_starve = 0;
      else if (t_ap == 1 && t_own == 0 && t_win == 0 && m_starve < 255)
        m_starve = m_starve + 1;
      if (hready) m_data = t_own;
      m_hand = (t_win != t_own) ? 1 : 0;
      m_own = t_win;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int own, tr, ap, lk, f, evt, mlock;
    own = m_own;
    tr = trans_of(own);
    ap = (hready && (tr == 0 || tr == 2)) ? 1 : 0;
    lk = (ap == 1 && hlock[own] && hbusreq[own]) ? 1 : 0;
    evt = 0;
    if (!rst && ap == 1 && lk == 0) begin
      void'(pick(own, f));
      evt = f;
    end
    mlock = (m_locked == 1 && tr != 0) ? 1 : 0;
    chk("cyc_hgrant", 8'(hgrant), (own == 1) ? 8'h2 : 8'h1);
    chk("cyc_hmaster", 8'(hmaster), 8'(own));
    chk("cyc_hmaster_data", 8'(hmaster_data), 8'(m_data));
    chk("cyc_handover", 8'(handover), 8'(m_hand));
    chk("cyc_hmastlock", 8'(hmastlock), 8'(mlock));
    chk("cyc_starve_evt", 8'(starve_evt), 8'(evt));
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic [1:0] req, input logic [1:0] lk, input logic [1:0] t0,
                     input logic [1:0] t1, input logic rdy, input logic bst);
    hbusreq = req; hlock = lk; htrans_m = {t1, t0}; hready = rdy; reflex_boost = bst;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_hgrant", 8'(hgrant), 8'h1);
    chk("rst_hmaster", 8'(hmaster), 8'h0);
    chk("rst_hmaster_data", 8'(hmaster_data), 8'h0);
    chk("rst_handover", 8'(handover), 8'h0);
    chk("rst_starve_evt", 8'(starve_evt), 8'h0);
    chk("rst_hmastlock", 8'(hmastlock), 8'h0);

    // Only M1 requests while M0 idles.
    drv(2'b10, 2'b00, T_IDLE, T_IDLE, 1'b1, 1'b0); step();
    chk("solo_hgrant", 8'(hgrant), 8'h2);
    chk("solo_hmaster", 8'(hmaster), 8'h1);
    chk("solo_handover", 8'(handover), 8'h1);
    chk("solo_data_lag", 8'(hmaster_data), 8'h0);
    drv(2'b10, 2'b00, T_IDLE, T_NSEQ, 1'b1, 1'b0); step();
    chk("solo_data", 8'(hmaster_data), 8'h1);
    chk("solo_handover_pulse", 8'(handover), 8'h0);
    drv(2'b00, 2'b00, T_IDLE, T_IDLE, 1'b1, 1'b0); step();
    chk("park_hgrant", 8'(hgrant), 8'h2);
    drv(2'b01, 2'b00, T_IDLE, T_IDLE, 1'b1, 1'b0); step();
    chk("back_hgrant", 8'(hgrant), 8'h1);

    // Beat limit: 6-beat INCR by M0, no switch mid-SEQ.
    drv(2'b11, 2'b00, T_NSEQ, T_IDLE, 1'b1, 1'b0); step();
    for (int i = 0; i < 5; i++) begin
      drv(2'b11, 2'b00, T_SEQ, T_IDLE, 1'b1, 1'b0); step();
      chk("hold_midseq", 8'(hgrant), 8'h1);
    end
    drv(2'b11, 2'b00, T_IDLE, T_IDLE, 1'b1, 1'b0); step();
    chk("hold_switch", 8'(hgrant), 8'h2);
    chk("hold_handover", 8'(handover), 8'h1);

    // Starvation: back-to-back singles by M0.
    drv(2'b01, 2'b00, T_IDLE, T_IDLE, 1'b1, 1'b0); step();
    for (int k = 0; k < 4; k++) begin
      drv(2'b11, 2'b00, T_NSEQ, T_IDLE, 1'b1, 1'b0);
      #1 chk("starve_pulse", 8'(starve_evt), (k == 3) ? 8'h1 : 8'h0);
      step();
    end
    chk("starve_hgrant", 8'(hgrant), 8'h2);

    // Locked sequence of 6 transfers by M0 while M1 starves.
    drv(2'b01, 2'b00, T_IDLE, T_IDLE, 1'b1, 1'b0); step();
    drv(2'b11, 2'b01, T_IDLE, T_IDLE, 1'b1, 1'b0);
    #1 chk("lock_pre", 8'(hmastlock), 8'h0);
    step();
    for (int k = 0; k < 6; k++) begin
      drv(2'b11, 2'b01, T_NSEQ, T_IDLE, 1'b1, 1'b0);
      #1 chk("lock_mastlock", 8'(hmastlock), 8'h1);
      step();
      chk("lock_hgrant", 8'(hgrant), 8'h1);
    end
    drv(2'b11, 2'b00, T_IDLE, T_IDLE, 1'b1, 1'b0);
    #1 chk("unlock_mastlock", 8'(hmastlock), 8'h0);
    chk("unlock_starve", 8'(starve_evt), 8'h1);
    step();
    chk("unlock_hgrant", 8'(hgrant), 8'h2);

    // Reflex boost rising mid-burst with wait states.
    drv(2'b01, 2'b00, T_IDLE, T_IDLE, 1'b1, 1'b0); step();
    drv(2'b11, 2'b00, T_NSEQ, T_IDLE, 1'b1, 1'b0); step();
    drv(2'b11, 2'b00, T_SEQ, T_IDLE, 1'b1, 1'b1); step();
    chk("boost_midburst", 8'(hgrant), 8'h1);
    repeat (3) begin
      drv(2'b11, 2'b00, T_SEQ, T_IDLE, 1'b0, 1'b1); step();
      chk("boost_wait", 8'(hgrant), 8'h1);
    end
    drv(2'b11, 2'b00, T_SEQ, T_IDLE, 1'b1, 1'b1); step();
    chk("boost_lastseq", 8'(hgrant), 8'h1);
    drv(2'b11, 2'b00, T_IDLE, T_IDLE, 1'b1, 1'b1); step();
    chk("boost_switch", 8'(hgrant), 8'h2);

    // Asynchronous reset during an M1 burst.
    drv(2'b10, 2'b00, T_IDLE, T_NSEQ, 1'b1, 1'b0); step();
    drv(2'b10, 2'b00, T_IDLE, T_SEQ, 1'b1, 1'b0); step();
    chk("pre_rst_data", 8'(hmaster_data), 8'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_hgrant", 8'(hgrant), 8'h1);
    chk("arst_hmaster", 8'(hmaster), 8'h0);
    chk("arst_hmaster_data", 8'(hmaster_data), 8'h0);
    chk("arst_handover", 8'(handover), 8'h0);
    step();
    rst = 1'b0;
    drv(2'b10, 2'b00, T_IDLE, T_IDLE, 1'b1, 1'b0); step();
    chk("post_rst_hgrant", 8'(hgrant), 8'h2);
    chk("post_rst_handover", 8'(handover), 8'h1);
    drv(2'b00, 2'b00, T_IDLE, T_IDLE, 1'b1, 1'b0);
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
